// File: rtl/packet_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : packet_data_buffer
// Purpose  : Byte-addressed circular endpoint buffer between the AHB word side
//            (1/2/4/8-byte accesses) and the USB packet side (1 byte/cycle).
//            Provides full/empty flags, occupancy, sticky overflow/underflow
//            errors and an optional registered high-watermark flag.
// Options  : define BUFFER_WATERMARK_EN to build the high_water comparator;
//            otherwise high_water is tied low.
// Note     : n_rst is a synchronous, ACTIVE-HIGH reset despite its name.
// Revision : 1.0 - initial release
// ============================================================================
module packet_data_buffer #(
    parameter  int DEPTH      = 64,
    parameter  int WORD_BYTES = 4,
    parameter  int HIGH_MARK  = 48,
    localparam int OW         = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    store_tx_data,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic [1:0]              data_size,
    input  logic                    get_rx_data,
    output logic [8*WORD_BYTES-1:0] rx_data,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    get_tx_packet_data,
    output logic [7:0]              tx_packet_data,
    output logic [OW-1:0]           buffer_occupancy,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow_err,
    output logic                    underflow_err,
    output logic                    high_water
);

    localparam int            AW          = $clog2(DEPTH);
    localparam int            WW          = 8 * WORD_BYTES;
    localparam logic [OW:0]   c_DEPTH_EXT = (OW+1)'(DEPTH);
    localparam logic [OW-1:0] c_DEPTH     = OW'(DEPTH);

    // Elaboration-time sanity checks on the configuration
    if ((DEPTH < 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 8");
    end
    if ((WORD_BYTES < 1) || (WORD_BYTES > 8) || ((WORD_BYTES & (WORD_BYTES - 1)) != 0)) begin : g_bad_word
        $error("WORD_BYTES must be a power of 2 between 1 and 8");
    end
    if ((HIGH_MARK < 1) || (HIGH_MARK > DEPTH)) begin : g_bad_mark
        $error("HIGH_MARK must lie in 1..DEPTH");
    end

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_count;
    logic [WW-1:0]   r_rx_data;
    logic [7:0]      r_tx_packet_data;
    logic            r_overflow_err;
    logic            r_underflow_err;

    logic [3:0]      w_n;
    logic            w_size_ok;
    logic [OW:0]     w_count_ext;
    logic [OW:0]     w_n_ext;
    logic            w_active;
    logic            w_word_wr;
    logic            w_byte_wr;
    logic            w_word_rd;
    logic            w_byte_rd;
    logic            w_ovf_set;
    logic            w_udf_set;
    logic [OW:0]     w_wr_bytes;
    logic [OW:0]     w_rd_bytes;
    logic [OW-1:0]   w_count_next;
    logic [WORD_BYTES-1:0] w_lane_en;
    logic [WW-1:0]   w_rd_word;

    // Access size decode: N = 2^data_size, invalid when wider than the word port
    assign w_n         = 4'd1 << data_size;
    assign w_size_ok   = (w_n <= 4'(WORD_BYTES));
    assign w_count_ext = {1'b0, r_count};
    assign w_n_ext     = (OW+1)'(w_n);

    // Reset and clear suppress every strobe for the cycle
    assign w_active  = !n_rst && !clear;

    // Write arbitration: word side wins; acceptance uses start-of-cycle count
    assign w_word_wr = w_active && store_tx_data && w_size_ok
                       && ((w_count_ext + w_n_ext) <= c_DEPTH_EXT);
    assign w_byte_wr = w_active && !store_tx_data && store_rx_packet_data
                       && (r_count < c_DEPTH);
    assign w_ovf_set = w_active
                       && ((store_tx_data && !w_word_wr)
                        || (store_tx_data && store_rx_packet_data)
                        || (!store_tx_data && store_rx_packet_data && !w_byte_wr));

    // Read arbitration: word side wins; acceptance uses start-of-cycle count
    assign w_word_rd = w_active && get_rx_data && w_size_ok
                       && (w_count_ext >= w_n_ext);
    assign w_byte_rd = w_active && !get_rx_data && get_tx_packet_data
                       && (r_count != '0);
    assign w_udf_set = w_active
                       && ((get_rx_data && !w_word_rd)
                        || (get_rx_data && get_tx_packet_data)
                        || (!get_rx_data && get_tx_packet_data && !w_byte_rd));

    assign w_wr_bytes   = w_word_wr ? w_n_ext : (w_byte_wr ? (OW+1)'(1) : '0);
    assign w_rd_bytes   = w_word_rd ? w_n_ext : (w_byte_rd ? (OW+1)'(1) : '0);
    // Accepted accesses keep the result within 0..DEPTH, so truncation is exact
    assign w_count_next = OW'(w_count_ext + w_wr_bytes - w_rd_bytes);

    // Per-lane enables and the zero-padded read word gathered from rd_ptr
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        assign w_lane_en[i]       = (4'(i) < w_n);
        assign w_rd_word[8*i +: 8] = w_lane_en[i] ? r_mem[r_rd_ptr + AW'(i)] : 8'h00;
    end

    // Byte storage: word writes fill N consecutive slots, byte writes fill one
    always_ff @(posedge clk) begin
        if (w_word_wr) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[r_wr_ptr + AW'(i)] <= tx_data[8*i +: 8];
                end
            end
        end else if (w_byte_wr) begin
            r_mem[r_wr_ptr] <= rx_packet_data;
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_rx_data        <= '0;
            r_tx_packet_data <= '0;
            r_overflow_err   <= 1'b0;
            r_underflow_err  <= 1'b0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_bytes);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd_bytes);
            r_count  <= w_count_next;
            if (w_word_rd) begin
                r_rx_data <= w_rd_word;
            end
            if (w_byte_rd) begin
                r_tx_packet_data <= r_mem[r_rd_ptr];
            end
            r_overflow_err  <= r_overflow_err  | w_ovf_set;
            r_underflow_err <= r_underflow_err | w_udf_set;
        end
    end

    assign rx_data          = r_rx_data;
    assign tx_packet_data   = r_tx_packet_data;
    assign buffer_occupancy = r_count;
    assign full             = (r_count == c_DEPTH);
    assign empty            = (r_count == '0);
    assign overflow_err     = r_overflow_err;
    assign underflow_err    = r_underflow_err;

`ifdef BUFFER_WATERMARK_EN
    logic r_high_water;

    // Watermark tracks the next count so it lines up with buffer_occupancy
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_high_water <= 1'b0;
        end else if (clear) begin
            r_high_water <= 1'b0;
        end else begin
            r_high_water <= (w_count_next >= OW'(HIGH_MARK));
        end
    end

    assign high_water = r_high_water;
`else
    assign high_water = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_data_buffer
// Purpose  : Self-checking bench for packet_data_buffer: a directed vector
//            table, hand-written fill/wrap/watermark sequences and a random
//            run, all checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_data_buffer;

    localparam int DEPTH = 64;
    localparam int WB    = 4;
    localparam int HM    = 48;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            clear = 1'b0;
    logic            store_tx_data = 1'b0;
    logic [8*WB-1:0] tx_data = '0;
    logic [1:0]      data_size = '0;
    logic            get_rx_data = 1'b0;
    logic [8*WB-1:0] rx_data;
    logic            store_rx_packet_data = 1'b0;
    logic [7:0]      rx_packet_data = '0;
    logic            get_tx_packet_data = 1'b0;
    logic [7:0]      tx_packet_data;
    logic [OW-1:0]   buffer_occupancy;
    logic            full;
    logic            empty;
    logic            overflow_err;
    logic            underflow_err;
    logic            high_water;

    packet_data_buffer #(.DEPTH(DEPTH), .WORD_BYTES(WB), .HIGH_MARK(HM)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .data_size            (data_size),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .full                 (full),
        .empty                (empty),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err),
        .high_water           (high_water)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          clr;
        bit          stx;
        logic [31:0] txd;
        logic [1:0]  sz;
        bit          grx;
        bit          srx;
        logic [7:0]  rxb;
        bit          gtx;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] erx;
        logic [7:0]  etx;
        int          eocc;
        bit          eovf;
        bit          eudf;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: the buffer is simply an ordered queue of bytes
    logic [7:0]  q[$];
    logic [31:0] m_rx  = '0;
    logic [7:0]  m_tx  = '0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(bit rst, bit clr, bit stx, logic [31:0] txd, logic [1:0] sz,
                               bit grx, bit srx, logic [7:0] rxb, bit gtx);
        op_t o;
        o.rst = rst; o.clr = clr; o.stx = stx; o.txd = txd; o.sz = sz;
        o.grx = grx; o.srx = srx; o.rxb = rxb; o.gtx = gtx;
        return o;
    endfunction

    function automatic void addv(op_t o, logic [31:0] erx, logic [7:0] etx, int eocc, bit eovf, bit eudf);
        vec_t v;
        v.op = o; v.erx = erx; v.etx = etx; v.eocc = eocc; v.eovf = eovf; v.eudf = eudf;
        tbl.push_back(v);
    endfunction

    function automatic void model(op_t o);
        int n   = 1 << o.sz;
        int cnt = q.size();
        int rd  = 0;
        logic [7:0] wb[$];
        if (o.rst) begin
            q.delete(); m_rx = '0; m_tx = '0; m_ovf = 1'b0; m_udf = 1'b0;
            return;
        end
        if (o.clr) begin
            q.delete();
            return;
        end
        if (o.grx) begin
            if (n > WB || cnt < n) m_udf = 1'b1;
            else begin
                m_rx = '0;
                for (int i = 0; i < n; i++) m_rx[8*i +: 8] = q[i];
                rd = n;
            end
            if (o.gtx) m_udf = 1'b1;
        end else if (o.gtx) begin
            if (cnt < 1) m_udf = 1'b1;
            else begin
                m_tx = q[0];
                rd = 1;
            end
        end
        if (o.stx) begin
            if (n > WB || cnt + n > DEPTH) m_ovf = 1'b1;
            else for (int i = 0; i < n; i++) wb.push_back(o.txd[8*i +: 8]);
            if (o.srx) m_ovf = 1'b1;
        end else if (o.srx) begin
            if (cnt >= DEPTH) m_ovf = 1'b1;
            else wb.push_back(o.rxb);
        end
        repeat (rd) void'(q.pop_front());
        foreach (wb[k]) q.push_back(wb[k]);
    endfunction

    task automatic check_model();
        bit exp_hw;
`ifdef BUFFER_WATERMARK_EN
        exp_hw = (q.size() >= HM);
`else
        exp_hw = 1'b0;
`endif
        chk("rx_data",       64'(rx_data),          64'(m_rx));
        chk("tx_byte",       64'(tx_packet_data),   64'(m_tx));
        chk("occupancy",     64'(buffer_occupancy), 64'(q.size()));
        chk("full",          64'(full),             64'(q.size() == DEPTH));
        chk("empty",         64'(empty),            64'(q.size() == 0));
        chk("overflow_err",  64'(overflow_err),     64'(m_ovf));
        chk("underflow_err", 64'(underflow_err),    64'(m_udf));
        chk("high_water",    64'(high_water),       64'(exp_hw));
    endtask

    // Apply one cycle of stimulus, advance the model, compare after the edge
    task automatic step(input op_t o);
        n_rst                = o.rst;
        clear                = o.clr;
        store_tx_data        = o.stx;
        tx_data              = o.txd;
        data_size            = o.sz;
        get_rx_data          = o.grx;
        store_rx_packet_data = o.srx;
        rx_packet_data       = o.rxb;
        get_tx_packet_data   = o.gtx;
        @(posedge clk);
        #1;
        model(o);
        check_model();
    endtask

    initial begin
        op_t o;
        //        rst clr stx txd           sz grx srx rxb    gtx      rx            tx     occ ovf udf
        addv(mk(1, 0, 0, 32'h0,        0, 0, 0, 8'h00, 0), 32'h0,        8'h00, 0, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h11, 0), 32'h0,        8'h00, 1, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h22, 0), 32'h0,        8'h00, 2, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h33, 0), 32'h0,        8'h00, 3, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h44, 0), 32'h0,        8'h00, 4, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        2, 1, 0, 8'h00, 0), 32'h44332211, 8'h00, 0, 0, 0);
        addv(mk(0, 0, 1, 32'hA1B2C3D4, 2, 0, 0, 8'h00, 0), 32'h44332211, 8'h00, 4, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h44332211, 8'hD4, 3, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h44332211, 8'hC3, 2, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h44332211, 8'hB2, 1, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h44332211, 8'hA1, 0, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h44332211, 8'hA1, 0, 0, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h55, 0), 32'h44332211, 8'hA1, 1, 0, 1);
        addv(mk(0, 0, 0, 32'h0,        1, 1, 0, 8'h00, 0), 32'h44332211, 8'hA1, 1, 0, 1);
        addv(mk(0, 0, 1, 32'h66,       0, 0, 1, 8'h77, 0), 32'h44332211, 8'hA1, 2, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        1, 1, 0, 8'h00, 1), 32'h00006655, 8'hA1, 0, 1, 1);
        addv(mk(1, 0, 0, 32'h0,        0, 0, 0, 8'h00, 0), 32'h0,        8'h00, 0, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h99, 0), 32'h0,        8'h00, 1, 0, 0);
        addv(mk(0, 0, 0, 32'h0,        3, 1, 0, 8'h00, 0), 32'h0,        8'h00, 1, 0, 1);
        addv(mk(0, 0, 1, 32'h12345678, 3, 0, 0, 8'h00, 0), 32'h0,        8'h00, 1, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 1, 0, 8'h00, 0), 32'h00000099, 8'h00, 0, 1, 1);
        addv(mk(0, 0, 1, 32'hCAFEBABE, 1, 0, 0, 8'h00, 0), 32'h00000099, 8'h00, 2, 1, 1);
        addv(mk(0, 1, 1, 32'h01020304, 2, 0, 0, 8'h00, 0), 32'h00000099, 8'h00, 0, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h00000099, 8'h00, 0, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h5A, 1), 32'h00000099, 8'h00, 1, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 1, 8'h6B, 1), 32'h00000099, 8'h5A, 1, 1, 1);
        addv(mk(0, 0, 0, 32'h0,        0, 0, 0, 8'h00, 1), 32'h00000099, 8'h6B, 0, 1, 1);

        // Directed vector table
        foreach (tbl[k]) begin
            step(tbl[k].op);
            chk($sformatf("row%0d_rx", k),  64'(rx_data),          64'(tbl[k].erx));
            chk($sformatf("row%0d_tx", k),  64'(tx_packet_data),   64'(tbl[k].etx));
            chk($sformatf("row%0d_occ", k), 64'(buffer_occupancy), 64'(tbl[k].eocc));
            chk($sformatf("row%0d_ovf", k), 64'(overflow_err),     64'(tbl[k].eovf));
            chk($sformatf("row%0d_udf", k), 64'(underflow_err),    64'(tbl[k].eudf));
        end

        // Fill to capacity, then a rejected 17th word write
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        for (int i = 0; i < 16; i++) step(mk(0, 0, 1, $urandom, 2, 0, 0, 0, 0));
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_occ",  64'(buffer_occupancy), 64'd64);
        chk("fill_ovf0", 64'(overflow_err), 64'd0);
        step(mk(0, 0, 1, 32'hDEADBEEF, 2, 0, 0, 0, 0));
        chk("over_ovf",  64'(overflow_err), 64'd1);
        chk("over_occ",  64'(buffer_occupancy), 64'd64);
        // Full with a simultaneous byte read: the write is still rejected
        step(mk(0, 0, 1, 32'h0BADF00D, 0, 0, 0, 0, 1));
        chk("full_rdwr_occ", 64'(buffer_occupancy), 64'd63);

        // Pointer wrap across the 63 -> 0 boundary
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 60; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 8'(i), 0));
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        chk("wrap_pre_tx", 64'(tx_packet_data), 64'd59);
        step(mk(0, 0, 1, 32'h03020100, 2, 0, 0, 0, 0));
        step(mk(0, 0, 1, 32'h07060504, 2, 0, 0, 0, 0));
        chk("wrap_occ", 64'(buffer_occupancy), 64'd8);
        step(mk(0, 0, 0, 0, 2, 1, 0, 0, 0));
        chk("wrap_rd0", 64'(rx_data), 64'h03020100);
        step(mk(0, 0, 0, 0, 2, 1, 0, 0, 0));
        chk("wrap_rd1", 64'(rx_data), 64'h07060504);
        chk("wrap_empty", 64'(empty), 64'd1);

`ifdef BUFFER_WATERMARK_EN
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++) step(mk(0, 0, 1, $urandom, 2, 0, 0, 0, 0));
        chk("hw_below", 64'(high_water), 64'd0);
        step(mk(0, 0, 1, $urandom, 2, 0, 0, 0, 0));
        chk("hw_at48", 64'(high_water), 64'd1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("hw_drop", 64'(high_water), 64'd0);
        step(mk(0, 0, 1, 32'h1, 0, 0, 1, 8'h2, 0));
        step(mk(0, 0, 1, $urandom, 2, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("hw_clr_occ", 64'(buffer_occupancy), 64'd0);
        chk("hw_clr_ovf", 64'(overflow_err), 64'd1);
        chk("hw_clr_hw",  64'(high_water), 64'd0);
`endif

        // Randomised traffic with alternating write-heavy / read-heavy phases
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3000; c++) begin
            bit wh;
            wh    = ((c / 150) % 2) == 0;
            o.rst = ($urandom_range(0, 249) == 0);
            o.clr = ($urandom_range(0, 79) == 0);
            o.stx = ($urandom_range(0, 99) < (wh ? 40 : 12));
            o.srx = ($urandom_range(0, 99) < (wh ? 40 : 12));
            o.grx = ($urandom_range(0, 99) < (wh ? 12 : 40));
            o.gtx = ($urandom_range(0, 99) < (wh ? 12 : 40));
            o.sz  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            o.txd = $urandom;
            o.rxb = 8'($urandom);
            step(o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
